// File: rtl/md_sequencer_pkg.sv
// Shared MD definitions: opcode encodings, sequencer states and op classification,
// used by Execute, Hazard and the multiply/divide sequencer.
package mips_md_pkg;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MFHI  = 4'd7;
   localparam logic [3:0] MD_MFLO  = 4'd8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   typedef enum logic [1:0] {
      MD_CLS_NONE      = 2'd0,
      MD_CLS_START     = 2'd1,
      MD_CLS_MOVE_TO   = 2'd2,
      MD_CLS_MOVE_FROM = 2'd3
   } md_class_e;

   function automatic md_class_e md_classify(input logic [3:0] op);
      md_class_e cls;
      cls = MD_CLS_NONE;
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: cls = MD_CLS_START;
         MD_MTHI, MD_MTLO:                   cls = MD_CLS_MOVE_TO;
         MD_MFHI, MD_MFLO:                   cls = MD_CLS_MOVE_FROM;
         default:                            cls = MD_CLS_NONE;
      endcase
      return cls;
   endfunction

   function automatic logic md_is_div(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_sequencer_calc.sv
// Combinational multiply/divide result generator for HI/LO, with a hold flag
// that tells the sequencer to leave HI/LO untouched on a zero divisor.
module md_calc
   import mips_md_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        hold
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] uq;
   logic [31:0] ur;
   logic        neg_q;
   logic        neg_r;

   // Sign-extended operands truncated to 64 bits give the two's-complement product.
   assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
   assign prod_u = {32'h0, rs} * {32'h0, rt};

   // Signed divide done on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   always_comb begin
      neg_q = 1'b0;
      neg_r = 1'b0;
      div_a = rs;
      div_b = rt;
      if (op == MD_DIV) begin
         neg_q = rs[31] ^ rt[31];
         neg_r = rs[31];
         div_a = rs[31] ? (~rs + 32'd1) : rs;
         div_b = rt[31] ? (~rt + 32'd1) : rt;
      end
      if (rt == '0)
         div_b = 32'd1;
   end

   assign uq = div_a / div_b;
   assign ur = div_a % div_b;

   always_comb begin
      res_hi = '0;
      res_lo = '0;
      case (op)
         MD_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         MD_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         MD_DIV, MD_DIVU: begin
            res_lo = neg_q ? (~uq + 32'd1) : uq;
            res_hi = neg_r ? (~ur + 32'd1) : ur;
         end
         default: begin
            res_hi = '0;
            res_lo = '0;
         end
      endcase
   end

   assign hold = md_is_div(op) && (rt == '0);

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning HI/LO: fixed-latency busy
// countdown per op, commit at countdown end, and the Decode MD stall.
module md_sequencer
   import mips_md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  e_md_op,
   input  logic [31:0] e_rs,
   input  logic [31:0] e_rt,
   input  logic        d_md_use,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        md_stall
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

   md_state_e   state, state_next;
   logic [CW-1:0] count, count_next;
   logic [31:0] hi_next, lo_next;
   logic [31:0] pend_hi, pend_hi_next;
   logic [31:0] pend_lo, pend_lo_next;
   logic        pend_hold, pend_hold_next;

   logic [31:0] calc_hi;
   logic [31:0] calc_lo;
   logic        calc_hold;
   md_class_e   op_cls;
   logic        start;

   md_calc u_calc (
      .op     (e_md_op),
      .rs     (e_rs),
      .rt     (e_rt),
      .res_hi (calc_hi),
      .res_lo (calc_lo),
      .hold   (calc_hold)
   );

   assign op_cls   = md_classify(e_md_op);
   assign start    = (op_cls == MD_CLS_START);
   assign busy     = (state == RUN);
   assign md_stall = d_md_use & (start | busy);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         hi        <= '0;
         lo        <= '0;
         pend_hi   <= '0;
         pend_lo   <= '0;
         pend_hold <= 1'b0;
      end else begin
         state     <= state_next;
         count     <= count_next;
         hi        <= hi_next;
         lo        <= lo_next;
         pend_hi   <= pend_hi_next;
         pend_lo   <= pend_lo_next;
         pend_hold <= pend_hold_next;
      end
   end

   always_comb begin
      state_next     = state;
      count_next     = count;
      hi_next        = hi;
      lo_next        = lo;
      pend_hi_next   = pend_hi;
      pend_lo_next   = pend_lo;
      pend_hold_next = pend_hold;
      case (state)
         IDLE: begin
            if (start) begin
               pend_hi_next   = calc_hi;
               pend_lo_next   = calc_lo;
               pend_hold_next = calc_hold;
               count_next     = md_is_div(e_md_op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
               state_next     = RUN;
            end else if (e_md_op == MD_MTHI) begin
               hi_next = e_rs;
            end else if (e_md_op == MD_MTLO) begin
               lo_next = e_rs;
            end
         end
         RUN: begin
            if (count == '0) begin
               if (!pend_hold) begin
                  hi_next = pend_hi;
                  lo_next = pend_lo;
               end
               state_next = IDLE;
            end else begin
               count_next = count - CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer with hand-computed HI/LO results.
module tb_md_sequencer;
   import mips_md_pkg::*;

   logic        clk;
   logic        reset;
   logic [3:0]  e_md_op;
   logic [31:0] e_rs;
   logic [31:0] e_rt;
   logic        d_md_use;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        md_stall;

   int checks;
   int failures;

   md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .e_md_op  (e_md_op),
      .e_rs     (e_rs),
      .e_rt     (e_rt),
      .d_md_use (d_md_use),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .md_stall (md_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      e_md_op = op;
      e_rs    = rs;
      e_rt    = rt;
   endtask

   // Issue one start op, verify busy for n cycles with HI/LO holding, then the commit.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input int n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      old_hi = hi;
      old_lo = lo;
      drive(op, rs, rt);
      step();
      drive(MD_NONE, '0, '0);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
         if (i == n - 1) begin
            chk({tag, "_hold_hi"}, hi, old_hi);
            chk({tag, "_hold_lo"}, lo, old_lo);
         end
         step();
      end
      chk({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      d_md_use = 1'b0;
      drive(MD_NONE, '0, '0);
      #12;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      reset = 1'b0;
      step();

      run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
      run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
      run_op("divu", MD_DIVU, 32'hFFFF_FFFF, 32'd10, 10, 32'h0000_0005, 32'h1999_9999);

      // Move-to then divide by zero: HI/LO must survive the commit.
      drive(MD_MTHI, 32'h1234, 32'h0);
      step();
      chk("mthi", hi, 32'h0000_1234);
      chk("mthi_busy", {31'b0, busy}, 32'd0);
      drive(MD_MTLO, 32'h5678, 32'h0);
      step();
      chk("mtlo", lo, 32'h0000_5678);
      run_op("div0", MD_DIV, 32'd5, 32'd0, 10, 32'h0000_1234, 32'h0000_5678);

      // mult 3x4 with an MD op held in Decode: stall for start cycle plus 5 busy cycles.
      d_md_use = 1'b1;
      drive(MD_MULT, 32'd3, 32'd4);
      #1;
      chk("stall_start", {31'b0, md_stall}, 32'd1);
      step();
      drive(MD_NONE, '0, '0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_busy", {31'b0, md_stall}, 32'd1);
         step();
      end
      chk("stall_end", {31'b0, md_stall}, 32'd0);
      chk("mult_lo", lo, 32'd12);
      chk("mult_hi", hi, 32'd0);
      d_md_use = 1'b0;
      drive(MD_MULT, 32'd3, 32'd4);
      #1;
      chk("nostall_nouse", {31'b0, md_stall}, 32'd0);

      // Move-to ops arriving during RUN are ignored.
      drive(MD_MULT, 32'hFFFF_FFFF, 32'd2);
      step();
      drive(MD_MTHI, 32'hDEAD, 32'h0);
      step();
      chk("run_mthi_ign", hi, 32'd0);
      drive(MD_MTLO, 32'hBEEF, 32'h0);
      step();
      chk("run_mtlo_ign", lo, 32'd12);
      drive(MD_NONE, '0, '0);
      step();
      step();
      step();
      chk("run_ign_busy", {31'b0, busy}, 32'd0);
      chk("run_ign_hi", hi, 32'hFFFF_FFFF);
      chk("run_ign_lo", lo, 32'hFFFF_FFFE);

      // Asynchronous reset at busy cycle 3 of a divide aborts it with no commit.
      drive(MD_DIV, 32'd100, 32'd7);
      step();
      drive(MD_NONE, '0, '0);
      step();
      step();
      chk("abort_pre_busy", {31'b0, busy}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      #3;
      reset = 1'b0;
      for (int i = 0; i < 12; i++) step();
      chk("abort_post_busy", {31'b0, busy}, 32'd0);
      chk("abort_post_hi", hi, 32'd0);
      chk("abort_post_lo", lo, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the five-stage pipeline. It owns HI/LO and accepts one mult/multu/div/divu/mthi/mtlo operation per cycle from the Execute stage. It runs a fixed-latency busy countdown per operation and commits results to HI/LO when the countdown ends. It also gives the hazard unit the stall that holds any MD-class instruction in Decode while an operation is starting or running.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high; clears all state immediately.
- `e_md_op`  in  4  — Execute-stage MD opcode from the shared package (NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO).
- `e_rs`  in  32  — forwarded rs operand in Execute.
- `e_rt`  in  32  — forwarded rt operand in Execute.
- `d_md_use`  in  1  — Decode instruction is any MD-class op (including mfhi/mflo/mthi/mtlo).
- `hi`  out  32  — architectural HI register.
- `lo`  out  32  — architectural LO register.
- `busy`  out  1  — countdown in progress.
- `md_stall`  out  1  — `d_md_use & (start | busy)`, where start = `e_md_op` ∈ {MULT, MULTU, DIV, DIVU}; combinational.

## Operation
- The FSM has two states, IDLE and RUN. On reset it is in IDLE with `hi`=0, `lo`=0, `busy`=0, count=0, and the pending result registers at 0.
- IDLE with a start op at a clock edge:
  - The result is computed from `e_rs`/`e_rt` and latched into pending_hi/pending_lo.
  - count loads N−1, where N = MULT_CYCLES or DIV_CYCLES.
  - The state goes to RUN.
- RUN:
  - count decrements each edge.
  - At the edge where count==0, pending is copied to HI/LO and the state returns to IDLE.
- Arithmetic:
  - mult: signed 32×32→64. multu: unsigned 32×32→64. HI gets the upper 32 bits and LO the lower 32 bits.
  - div/divu: LO = quotient, HI = remainder, truncated toward zero. The remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0: the countdown runs normally, but HI/LO keep their previous values at commit.
- MTHI/MTLO in IDLE: `hi` (resp. `lo`) takes `e_rs` at the edge. No busy is asserted.
- MFHI/MFLO: no state effect. The pipeline reads `hi`/`lo` directly.
- Any op arriving while in RUN is ignored. This includes mthi/mtlo. The hazard stall guarantees it cannot occur legally; the bench checks that it is ignored.
- Reset asserted mid-RUN aborts the operation immediately. No commit occurs and all outputs return to reset values.

## Timing
- A start accepted at edge k raises `busy` after edge k. `busy` stays high for exactly N cycles and falls on edge k+N.
- HI/LO show the new value in the same cycle `busy` falls.
- `md_stall` is high in the start cycle itself, since `busy` is not yet set. It stays high through every `busy` cycle, but only while `d_md_use` is high.
- The first legal following MD op sits in Execute in the cycle after `busy` falls. It sees the committed HI/LO.
- MTHI/MTLO latency is 1 edge: the value is visible on `hi`/`lo` in the next cycle.
- Back-to-back starts: the second is stalled in Decode, so there is never an overlap.

## Structure
- The shared package `mips_md_pkg` holds:
  - the 4-bit MD opcode constants;
  - the IDLE/RUN state encoding;
  - a helper classifying ops as start / move-to / move-from.
- Execute and Hazard use the same package for decode and stall classification.
- One sub-module, `md_calc`, is natural. It is the combinational 64-bit multiply/divide result generator, including the divide-by-zero hold flag.
- The FSM, counter and HI/LO registers stay in `md_sequencer`.

## Test plan
- multu: rs=0xFFFFFFFF, rt=2 → `busy` high for 5 cycles. Then hi=0x00000001, lo=0xFFFFFFFE. Before commit, hi/lo hold their old values.
- div: rs=0xFFFFFFF9 (−7), rt=2 → `busy` high for 10 cycles. Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div: rs=5, rt=0, preceded by mthi 0x1234 and mtlo 0x5678 → after 10 cycles hi=0x1234, lo=0x5678, and `busy` has dropped.
- mult (3×4), with mflo held in Decode (`d_md_use`=1) → `md_stall`=1 for 6 cycles (start + 5 busy). Then lo=12 and `md_stall`=0.
- During RUN, drive `e_md_op`=MTHI with rs=0xDEAD → the op is ignored. hi equals the mult result at commit.
- Assert `reset` asynchronously at busy cycle 3 of a div → `busy`, hi, lo go to 0 immediately. There is no commit after reset releases.
